dpc_dynamic_3x3: RTL and testbench
==================================

Name: dpc_dynamic_3x3

Overview:
- Dynamic dead-pixel correction stage that sits directly downstream of the 3x3 window generator.
- Consumes the flattened 3x3 window every cycle and flags the centre pixel as hot or cold against the min/max of its 8 neighbours plus a threshold.
- Replaces flagged pixels with the rounded mean of the 8 neighbours.
- Counts corrected pixels per frame and reports the count at end of frame.

Parameters:
- DW, 8, pixel data width.
- CNTW, 20, width of the per-frame correction counter.

Ports:
- i_Sys_clk  input  1  system clock.
- i_Rst  input  1  reset; synchronous, active-high.
- i_dpc_en  input  1  correction enable; sampled at frame start.
- i_thr  input  DW  detection threshold; sampled at frame start.
- i_field_vld  input  1  frame valid from the window stage.
- i_pixel_vld  input  1  pixel valid qualifier.
- i_win_data  input  DW*9  window; element k = i_win_data[DW*k +: DW], k=0..8, row-major; k=4 is the centre.
- o_field_vld  output  1  i_field_vld delayed 4 cycles.
- o_pixel_vld  output  1  i_pixel_vld delayed 4 cycles.
- o_image_data  output  DW  corrected centre pixel; 0 when o_field_vld=0.
- o_dpc_flag  output  1  high for the output pixel that was replaced.
- o_dpc_cnt  output  CNTW  corrected-pixel count of the last completed frame.
- o_cnt_vld  output  1  one-cycle pulse when o_dpc_cnt updates.

Behaviour:
- Reset (i_Rst=1 at clock edge):
  - All pipeline registers, outputs, counter, o_dpc_cnt and o_cnt_vld are cleared to 0.
  - Frame config is cleared to cfg_en=0, cfg_thr=0.
  - Reset mid-frame discards in-flight pixels. The following frame is processed normally from its rising i_field_vld.
- Frame config: on the cycle i_field_vld goes 0->1 (edge detected against its previous registered value), cfg_en<=i_dpc_en and cfg_thr<=i_thr. Changes to i_dpc_en or i_thr mid-frame have no effect until the next frame.
- Pipeline: no stall; advances every cycle. Valids travel with the data. Fixed latency is 4 cycles from input to output.
  - S1: register the window, i_field_vld and i_pixel_vld.
  - S2: nmax/nmin = max/min of the 8 neighbours (k≠4); nsum = sum of the 8 neighbours, DW+3 bits; register the centre.
  - S3, all compares in DW+1 bits with no wrap:
    - hot = centre > nmax + cfg_thr.
    - cold = centre + cfg_thr < nmin.
    - repl = (nsum + 4) >> 3, truncated to DW bits.
  - S4:
    - corr = cfg_en & field & pixel & (hot|cold).
    - o_image_data = corr ? repl : centre, forced to 0 when field=0.
    - o_dpc_flag = corr.
- Equality at the threshold (centre == nmax+thr, or centre+thr == nmin) is NOT corrected.
- Counter:
  - Increments on each S4 cycle with corr=1 and saturates at 2^CNTW-1.
  - On the cycle after the output field falls (o_field_vld 1->0): o_dpc_cnt <= counter value including any correction in the last pixel; o_cnt_vld=1 for one cycle; counter cleared.
  - Pixels with field=1 and pixel=0 pass through as the centre and are never counted.
- Blanking: at least 4 cycles of i_field_vld=0 are required between frames, so config is never swapped under the previous frame's in-flight pixels. Shorter blanking is out of contract.
- A rising and a falling i_field_vld edge never share a cycle, so the config update and the count latch never collide.

Test Plan:
- Reset: hold i_Rst 3 cycles while driving valid data -> all outputs 0. First window after release appears at o_image_data exactly 4 cycles after input.
- Flat frame, all 9 = 100, thr=20, en=1 -> o_image_data=100, o_dpc_flag=0 throughout; at frame end o_dpc_cnt=0 with a single o_cnt_vld pulse.
- Hot pixel: neighbours 100, centre 255, thr=20 -> output 100, flag=1. Cold pixel: neighbours 50..57, centre 0, thr=5 -> output (428+4)>>3=54, flag=1. Frame containing these two -> o_dpc_cnt=2.
- Threshold boundary, neighbours max 250, thr=5:
  - centre 255 -> not corrected (equal).
  - thr=4 -> corrected.
  - neighbours max 250, thr=10 -> 260 compare with no wrap, centre 255 not corrected.
- Enable framing: en=0 at frame start, raised mid-frame with hot pixels present -> frame passes unchanged, count 0. Next frame with en=1 -> corrections occur.
- Reset mid-frame after 3 corrections -> counter and outputs cleared, no o_cnt_vld for the aborted frame. Next full frame with 1 hot pixel -> o_dpc_cnt=1.

Source files
------------

// File: rtl/dpc_dynamic_3x3.sv
// Dynamic dead-pixel correction on a 3x3 window: flags hot/cold centres against
// neighbour min/max plus a per-frame threshold and replaces them with the neighbour mean.
module dpc_dynamic_3x3 #(
    parameter int DW   = 8,
    parameter int CNTW = 20
) (
    input  logic              i_Sys_clk,
    input  logic              i_Rst,
    input  logic              i_dpc_en,
    input  logic [DW-1:0]     i_thr,
    input  logic              i_field_vld,
    input  logic              i_pixel_vld,
    input  logic [DW*9-1:0]   i_win_data,
    output logic              o_field_vld,
    output logic              o_pixel_vld,
    output logic [DW-1:0]     o_image_data,
    output logic              o_dpc_flag,
    output logic [CNTW-1:0]   o_dpc_cnt,
    output logic              o_cnt_vld
);

    // frame config
    logic              cfg_en_q;
    logic [DW-1:0]     cfg_thr_q;
    logic              rise_d;

    // S1
    logic [DW*9-1:0]   win1_q;
    logic              fld1_q, pix1_q;

    // S2
    logic [DW-1:0]     nmax_d, nmin_d, px_d;
    logic [DW+2:0]     nsum_d;
    logic [DW-1:0]     nmax2_q, nmin2_q, ctr2_q;
    logic [DW+2:0]     nsum2_q;
    logic              fld2_q, pix2_q;

    // S3
    logic [DW:0]       thr_e;
    logic              hot_d, cold_d;
    logic [DW+2:0]     sum4_d;
    logic [DW-1:0]     repl_d;
    logic              hot3_q, cold3_q;
    logic [DW-1:0]     repl3_q, ctr3_q;
    logic              fld3_q, pix3_q;

    // S4 and counter
    logic              corr_d, fall_d;
    logic [DW-1:0]     img_d;
    logic [DW-1:0]     img4_q;
    logic              flag4_q, fld4_q, pix4_q;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]   dpc_cnt_q;
    logic              cnt_vld_q;

    // fld1_q doubles as the previous-cycle field for edge detection
    assign rise_d = i_field_vld & ~fld1_q;

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            cfg_en_q  <= 1'b0;
            cfg_thr_q <= '0;
        end else if (rise_d) begin
            cfg_en_q  <= i_dpc_en;
            cfg_thr_q <= i_thr;
        end
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            win1_q <= '0;
            fld1_q <= 1'b0;
            pix1_q <= 1'b0;
        end else begin
            win1_q <= i_win_data;
            fld1_q <= i_field_vld;
            pix1_q <= i_pixel_vld;
        end
    end

    always_comb begin
        nmax_d = '0;
        nmin_d = '1;
        nsum_d = '0;
        px_d   = '0;
        for (int k = 0; k < 9; k++) begin
            if (k != 4) begin
                px_d   = win1_q[DW*k +: DW];
                nsum_d = nsum_d + {3'b000, px_d};
                if (px_d > nmax_d) nmax_d = px_d;
                if (px_d < nmin_d) nmin_d = px_d;
            end
        end
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            nmax2_q <= '0;
            nmin2_q <= '0;
            nsum2_q <= '0;
            ctr2_q  <= '0;
            fld2_q  <= 1'b0;
            pix2_q  <= 1'b0;
        end else begin
            nmax2_q <= nmax_d;
            nmin2_q <= nmin_d;
            nsum2_q <= nsum_d;
            ctr2_q  <= win1_q[DW*4 +: DW];
            fld2_q  <= fld1_q;
            pix2_q  <= pix1_q;
        end
    end

    // one extra bit so nmax+thr and centre+thr cannot wrap
    always_comb begin
        thr_e  = {1'b0, cfg_thr_q};
        hot_d  = {1'b0, ctr2_q} > ({1'b0, nmax2_q} + thr_e);
        cold_d = ({1'b0, ctr2_q} + thr_e) < {1'b0, nmin2_q};
        sum4_d = nsum2_q + (DW+3)'(4);
        repl_d = sum4_d[DW+2:3];
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            hot3_q  <= 1'b0;
            cold3_q <= 1'b0;
            repl3_q <= '0;
            ctr3_q  <= '0;
            fld3_q  <= 1'b0;
            pix3_q  <= 1'b0;
        end else begin
            hot3_q  <= hot_d;
            cold3_q <= cold_d;
            repl3_q <= repl_d;
            ctr3_q  <= ctr2_q;
            fld3_q  <= fld2_q;
            pix3_q  <= pix2_q;
        end
    end

    always_comb begin
        corr_d = cfg_en_q & fld3_q & pix3_q & (hot3_q | cold3_q);
        img_d  = '0;
        if (fld3_q) img_d = corr_d ? repl3_q : ctr3_q;
        // last output pixel of the frame is leaving S4 on this edge
        fall_d = fld4_q & ~fld3_q;
        cnt_d  = cnt_q;
        if (fall_d)                   cnt_d = '0;
        else if (corr_d && cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            img4_q    <= '0;
            flag4_q   <= 1'b0;
            fld4_q    <= 1'b0;
            pix4_q    <= 1'b0;
            cnt_q     <= '0;
            dpc_cnt_q <= '0;
            cnt_vld_q <= 1'b0;
        end else begin
            img4_q    <= img_d;
            flag4_q   <= corr_d;
            fld4_q    <= fld3_q;
            pix4_q    <= pix3_q;
            cnt_q     <= cnt_d;
            cnt_vld_q <= fall_d;
            if (fall_d) dpc_cnt_q <= cnt_q;
        end
    end

    assign o_field_vld  = fld4_q;
    assign o_pixel_vld  = pix4_q;
    assign o_image_data = img4_q;
    assign o_dpc_flag   = flag4_q;
    assign o_dpc_cnt    = dpc_cnt_q;
    assign o_cnt_vld    = cnt_vld_q;

endmodule

// File: tb/tb_dpc_dynamic_3x3.sv
// Directed bench for dpc_dynamic_3x3: per-scenario tasks with hand-computed expectations.
module tb_dpc_dynamic_3x3;
    localparam int DW   = 8;
    localparam int CNTW = 4;
    localparam int NMAX = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, en, field, pix;
    logic [DW-1:0]     thr;
    logic [DW*9-1:0]   win;
    logic              o_fld, o_pix, o_flag, o_cvld;
    logic [DW-1:0]     o_img;
    logic [CNTW-1:0]   o_cnt;

    dpc_dynamic_3x3 #(.DW(DW), .CNTW(CNTW)) dut (
        .i_Sys_clk(clk), .i_Rst(rst), .i_dpc_en(en), .i_thr(thr),
        .i_field_vld(field), .i_pixel_vld(pix), .i_win_data(win),
        .o_field_vld(o_fld), .o_pixel_vld(o_pix), .o_image_data(o_img),
        .o_dpc_flag(o_flag), .o_dpc_cnt(o_cnt), .o_cnt_vld(o_cvld)
    );

    int nvec = 0;
    int nerr = 0;

    logic [DW*9-1:0] win_a [NMAX];
    logic            pix_a [NMAX];
    logic            en_a  [NMAX];
    logic [DW-1:0]   thr_a [NMAX];
    logic [DW-1:0]   got_img  [NMAX];
    logic            got_flag [NMAX];
    logic            got_fld  [NMAX];
    int              pulses;
    logic [CNTW-1:0] got_cnt;
    logic [DW-1:0]   blank_img;
    logic            blank_fld;

    function automatic logic [DW*9-1:0] mkw(input logic [DW-1:0] nb, input logic [DW-1:0] c);
        logic [DW*9-1:0] w;
        for (int k = 0; k < 9; k++) w[DW*k +: DW] = (k == 4) ? c : nb;
        return w;
    endfunction

    // neighbours base, base+1, ..., base+7 in scan order
    function automatic logic [DW*9-1:0] mkramp(input int base, input logic [DW-1:0] c);
        logic [DW*9-1:0] w;
        for (int k = 0; k < 9; k++)
            w[DW*k +: DW] = (k == 4) ? c : DW'(base + ((k < 4) ? k : k - 1));
        return w;
    endfunction

    task automatic set_px(input int i, input logic [DW*9-1:0] w, input logic p,
                          input logic e, input logic [DW-1:0] t);
        win_a[i] = w; pix_a[i] = p; en_a[i] = e; thr_a[i] = t;
    endtask

    // drives n pixels then blanking; records aligned outputs and count pulses
    task automatic run_frame(input int n);
        pulses = 0;
        got_cnt = '0;
        for (int i = 0; i < n + 9; i++) begin
            @(negedge clk);
            if (i >= 4 && i - 4 < n) begin
                got_img[i-4]  = o_img;
                got_flag[i-4] = o_flag;
                got_fld[i-4]  = o_fld;
            end
            if (i == n + 5) begin
                blank_img = o_img;
                blank_fld = o_fld;
            end
            if (o_cvld) begin
                pulses++;
                got_cnt = o_cnt;
            end
            if (i < n) begin
                field = 1'b1; pix = pix_a[i]; win = win_a[i]; en = en_a[i]; thr = thr_a[i];
            end else begin
                field = 1'b0; pix = 1'b0; win = '0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; field = 1'b1; pix = 1'b1; en = 1'b1; thr = 8'd20; win = mkw(8'd100, 8'd255);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if (o_img !== '0 || o_flag !== 1'b0 || o_fld !== 1'b0 || o_pix !== 1'b0 ||
                o_cnt !== '0 || o_cvld !== 1'b0) begin
                nerr++;
                $display("FAIL reset_hold cyc%0d: img=%0d flag=%b fld=%b pix=%b cnt=%0d cvld=%b, want all 0",
                         i, o_img, o_flag, o_fld, o_pix, o_cnt, o_cvld);
            end
        end
        rst = 1'b0; win = mkw(8'd77, 8'd77);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                nvec++;
                if (o_fld !== 1'b0) begin
                    nerr++;
                    $display("FAIL reset_latency_early: fld=%b, want 0", o_fld);
                end
            end
        end
        nvec++;
        if (o_img !== 8'd77 || o_fld !== 1'b1 || o_flag !== 1'b0) begin
            nerr++;
            $display("FAIL reset_first_px: img=%0d fld=%b flag=%b, want 77 1 0", o_img, o_fld, o_flag);
        end
        field = 1'b0; pix = 1'b0;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (o_cvld) begin pulses++; got_cnt = o_cnt; end
        end
        nvec++;
        if (pulses != 1 || got_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_frame_cnt: pulses=%0d cnt=%0d, want 1 0", pulses, got_cnt);
        end
    endtask

    task automatic test_flat;
        for (int i = 0; i < 6; i++) set_px(i, mkw(8'd100, 8'd100), 1'b1, 1'b1, 8'd20);
        run_frame(6);
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (got_img[i] !== 8'd100 || got_flag[i] !== 1'b0 || got_fld[i] !== 1'b1) begin
                nerr++;
                $display("FAIL flat px%0d: img=%0d flag=%b fld=%b, want 100 0 1",
                         i, got_img[i], got_flag[i], got_fld[i]);
            end
        end
        nvec++;
        if (pulses != 1 || got_cnt !== '0 || blank_img !== '0 || blank_fld !== 1'b0) begin
            nerr++;
            $display("FAIL flat_end: pulses=%0d cnt=%0d blank_img=%0d blank_fld=%b, want 1 0 0 0",
                     pulses, got_cnt, blank_img, blank_fld);
        end
    endtask

    task automatic test_hot_cold;
        logic [DW-1:0] ei [4] = '{8'd100, 8'd100, 8'd54, 8'd255};
        logic          ef [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        set_px(0, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd5);
        set_px(1, mkw(8'd100, 8'd100), 1'b1, 1'b1, 8'd5);
        set_px(2, mkramp(50, 8'd0),    1'b1, 1'b1, 8'd5);
        set_px(3, mkw(8'd100, 8'd255), 1'b0, 1'b1, 8'd5);
        run_frame(4);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (got_img[i] !== ei[i] || got_flag[i] !== ef[i]) begin
                nerr++;
                $display("FAIL hot_cold px%0d: img=%0d flag=%b, want %0d %b",
                         i, got_img[i], got_flag[i], ei[i], ef[i]);
            end
        end
        nvec++;
        if (pulses != 1 || got_cnt !== 4'd2) begin
            nerr++;
            $display("FAIL hot_cold_cnt: pulses=%0d cnt=%0d, want 1 2", pulses, got_cnt);
        end
    endtask

    task automatic test_threshold;
        logic [DW-1:0] t  [3]    = '{8'd5, 8'd4, 8'd10};
        logic [DW-1:0] c1 [3]    = '{8'd45, 8'd45, 8'd0};
        logic [DW-1:0] n1 [3]    = '{8'd50, 8'd50, 8'd5};
        logic [DW-1:0] ei [3][2] = '{'{8'd255, 8'd45}, '{8'd250, 8'd50}, '{8'd255, 8'd0}};
        logic          ef [3][2] = '{'{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b0, 1'b0}};
        logic [CNTW-1:0] ec [3]  = '{4'd0, 4'd2, 4'd0};
        for (int f = 0; f < 3; f++) begin
            set_px(0, mkw(8'd250, 8'd255), 1'b1, 1'b1, t[f]);
            set_px(1, mkw(n1[f], c1[f]),   1'b1, 1'b1, t[f]);
            run_frame(2);
            for (int i = 0; i < 2; i++) begin
                nvec++;
                if (got_img[i] !== ei[f][i] || got_flag[i] !== ef[f][i]) begin
                    nerr++;
                    $display("FAIL thr%0d px%0d: img=%0d flag=%b, want %0d %b",
                             t[f], i, got_img[i], got_flag[i], ei[f][i], ef[f][i]);
                end
            end
            nvec++;
            if (pulses != 1 || got_cnt !== ec[f]) begin
                nerr++;
                $display("FAIL thr%0d_cnt: pulses=%0d cnt=%0d, want 1 %0d", t[f], pulses, got_cnt, ec[f]);
            end
        end
    endtask

    task automatic test_enable_framing;
        set_px(0, mkw(8'd100, 8'd255), 1'b1, 1'b0, 8'd20);
        set_px(1, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd20);
        set_px(2, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd20);
        run_frame(3);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (got_img[i] !== 8'd255 || got_flag[i] !== 1'b0) begin
                nerr++;
                $display("FAIL en_off px%0d: img=%0d flag=%b, want 255 0", i, got_img[i], got_flag[i]);
            end
        end
        nvec++;
        if (pulses != 1 || got_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL en_off_cnt: pulses=%0d cnt=%0d, want 1 0", pulses, got_cnt);
        end
        // threshold raised mid-frame must not take effect until the next frame
        set_px(0, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd20);
        set_px(1, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd255);
        run_frame(2);
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (got_img[i] !== 8'd100 || got_flag[i] !== 1'b1) begin
                nerr++;
                $display("FAIL en_on px%0d: img=%0d flag=%b, want 100 1", i, got_img[i], got_flag[i]);
            end
        end
        nvec++;
        if (pulses != 1 || got_cnt !== 4'd2) begin
            nerr++;
            $display("FAIL en_on_cnt: pulses=%0d cnt=%0d, want 1 2", pulses, got_cnt);
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 18; i++) set_px(i, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd20);
        run_frame(18);
        nvec++;
        if (got_flag[17] !== 1'b1 || got_img[17] !== 8'd100) begin
            nerr++;
            $display("FAIL sat_last_px: img=%0d flag=%b, want 100 1", got_img[17], got_flag[17]);
        end
        nvec++;
        if (pulses != 1 || got_cnt !== 4'd15) begin
            nerr++;
            $display("FAIL sat_cnt: pulses=%0d cnt=%0d, want 1 15", pulses, got_cnt);
        end
    endtask

    task automatic test_reset_midframe;
        en = 1'b1; thr = 8'd20;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (o_cvld) pulses++;
            if (i >= 4) begin
                nvec++;
                if (o_img !== 8'd100 || o_flag !== 1'b1) begin
                    nerr++;
                    $display("FAIL midrst_pre px%0d: img=%0d flag=%b, want 100 1", i - 4, o_img, o_flag);
                end
            end
            field = 1'b1; pix = 1'b1; win = mkw(8'd100, 8'd255);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (o_cvld) pulses++;
        end
        nvec++;
        if (o_img !== '0 || o_flag !== 1'b0 || o_fld !== 1'b0 || o_cnt !== '0) begin
            nerr++;
            $display("FAIL midrst_clear: img=%0d flag=%b fld=%b cnt=%0d, want 0 0 0 0",
                     o_img, o_flag, o_fld, o_cnt);
        end
        rst = 1'b0; field = 1'b0; pix = 1'b0; win = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_cvld) pulses++;
        end
        nvec++;
        if (pulses != 0) begin
            nerr++;
            $display("FAIL midrst_nopulse: pulses=%0d, want 0", pulses);
        end
        set_px(0, mkw(8'd100, 8'd100), 1'b1, 1'b1, 8'd20);
        set_px(1, mkw(8'd100, 8'd255), 1'b1, 1'b1, 8'd20);
        set_px(2, mkw(8'd100, 8'd100), 1'b1, 1'b1, 8'd20);
        run_frame(3);
        nvec++;
        if (got_img[1] !== 8'd100 || got_flag[1] !== 1'b1 || pulses != 1 || got_cnt !== 4'd1) begin
            nerr++;
            $display("FAIL midrst_next: img=%0d flag=%b pulses=%0d cnt=%0d, want 100 1 1 1",
                     got_img[1], got_flag[1], pulses, got_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; thr = '0; field = 1'b0; pix = 1'b0; win = '0;
        test_reset;
        test_flat;
        test_hot_cold;
        test_threshold;
        test_enable_framing;
        test_saturate;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
